// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: upstream, ALU-side and downstream signals of the ALU
// operation sequencer. Optional statistics ports exist only when
// ALU_SEQ_STATS_EN is defined.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_carry;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0]       op_count;
  logic             stall;
`endif

  // Environment view: upstream producer, external ALU datapath, downstream sink
  modport master (
    output in_valid, in_a, in_b, in_sel, alu_res, alu_cout, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_zero,
           out_carry
`ifdef ALU_SEQ_STATS_EN
    , input op_count, stall
`endif
  );

  // Sequencer view
  modport slave (
    input  in_valid, in_a, in_b, in_sel, alu_res, alu_cout, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_zero,
           out_carry
`ifdef ALU_SEQ_STATS_EN
    , output op_count, stall
`endif
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU operation per handshake, holds the operands
// for the external combinational ALU for SETTLE_CYCLES cycles, captures result
// and flags, and presents them downstream with a valid/ready handshake.
// Optional macro ALU_SEQ_STATS_EN adds op_count (saturating transfer counter)
// and stall (HOLD with out_ready low).
module alu_op_sequencer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1   // legal 1..15
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_op_sequencer_if.slave    bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_zero_q, out_zero_d;
  logic             out_carry_q, out_carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0]       op_count_q, op_count_d;
`endif

  // State and output registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_carry_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_SEQ_STATS_EN
      op_count_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      out_carry_q <= out_carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_SEQ_STATS_EN
      op_count_q  <= op_count_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;
    out_carry_d = out_carry_q;
`ifdef ALU_SEQ_STATS_EN
    op_count_d  = op_count_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          alu_a_d   = bus.in_a;
          alu_b_d   = bus.in_b;
          alu_sel_d = bus.in_sel;
          cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          out_data_d  = bus.alu_res;
          out_zero_d  = (bus.alu_res == '0);
          // Carry/borrow is only meaningful for ADD/SUB (sel[1] set)
          out_carry_d = bus.alu_cout & alu_sel_q[1];
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
`ifdef ALU_SEQ_STATS_EN
          if (op_count_q != 8'hFF) begin
            op_count_d = op_count_q + 8'd1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags follow the state being entered so they are registered
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_carry = out_carry_q;
`ifdef ALU_SEQ_STATS_EN
  assign bus.op_count  = op_count_q;
  // Same-cycle view of downstream backpressure
  assign bus.stall     = (state_q == HOLD) && !bus.out_ready;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vectors for alu_op_sequencer with an external
// 4-bit ALU model. One DUT uses SETTLE_CYCLES=1, a second SETTLE_CYCLES=3.
// Statistics checks compile in when ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(W)) bus1 ();
  alu_op_sequencer_if #(.WIDTH(W)) bus3 ();

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(3)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  // External ALU: AND/OR drive cout high (don't-care) so the block's masking shows
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] sel);
    case (sel)
      2'b00:   alu_fn = {1'b1, a & b};
      2'b01:   alu_fn = {1'b1, a | b};
      2'b10:   alu_fn = {1'b0, a} + {1'b0, b};
      default: alu_fn = {(a < b), 4'(a - b)};
    endcase
  endfunction

  always_comb {bus1.alu_cout, bus1.alu_res} = alu_fn(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
  always_comb {bus3.alu_cout, bus3.alu_res} = alu_fn(bus3.alu_a, bus3.alu_b, bus3.alu_sel);

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic [3:0] d;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full operation on the SETTLE_CYCLES=1 DUT with out_ready held high
  task automatic do_op1(input vec_t v, input int idx);
    check($sformatf("v%0d_in_ready_idle", idx), 8'(bus1.in_ready), 8'd1);
    bus1.in_valid  = 1'b1;
    bus1.in_a      = v.a;
    bus1.in_b      = v.b;
    bus1.in_sel    = v.sel;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check($sformatf("v%0d_settle_valid", idx), 8'(bus1.out_valid), 8'd0);
    check($sformatf("v%0d_settle_ready", idx), 8'(bus1.in_ready), 8'd0);
    check($sformatf("v%0d_alu_a", idx), 8'(bus1.alu_a), 8'(v.a));
    check($sformatf("v%0d_alu_b", idx), 8'(bus1.alu_b), 8'(v.b));
    check($sformatf("v%0d_alu_sel", idx), 8'(bus1.alu_sel), 8'(v.sel));
    @(negedge clk);
    check($sformatf("v%0d_out_valid", idx), 8'(bus1.out_valid), 8'd1);
    check($sformatf("v%0d_out_data", idx), 8'(bus1.out_data), 8'(v.d));
    check($sformatf("v%0d_out_zero", idx), 8'(bus1.out_zero), 8'(v.z));
    check($sformatf("v%0d_out_carry", idx), 8'(bus1.out_carry), 8'(v.c));
    @(negedge clk);
    check($sformatf("v%0d_post_valid", idx), 8'(bus1.out_valid), 8'd0);
    check($sformatf("v%0d_post_ready", idx), 8'(bus1.in_ready), 8'd1);
    check($sformatf("v%0d_post_data", idx), 8'(bus1.out_data), 8'(v.d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             a        b        sel    d        z     c
    vecs[0] = '{4'b1101, 4'b1011, 2'b00, 4'b1001, 1'b0, 1'b0}; // AND
    vecs[1] = '{4'b0100, 4'b0010, 2'b00, 4'b0000, 1'b1, 1'b0}; // AND zero
    vecs[2] = '{4'b1111, 4'b0001, 2'b10, 4'b0000, 1'b1, 1'b1}; // ADD wrap
    vecs[3] = '{4'b1010, 4'b0101, 2'b01, 4'b1111, 1'b0, 1'b0}; // OR
    vecs[4] = '{4'b0011, 4'b0101, 2'b11, 4'b1110, 1'b0, 1'b1}; // SUB borrow
    vecs[5] = '{4'b0101, 4'b0101, 2'b11, 4'b0000, 1'b1, 1'b0}; // SUB zero
    vecs[6] = '{4'b0011, 4'b0100, 2'b10, 4'b0111, 1'b0, 1'b0}; // ADD no carry
    vecs[7] = '{4'b0000, 4'b0000, 2'b01, 4'b0000, 1'b1, 1'b0}; // OR zero

    rst = 1'b1;
    rst3 = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_sel = '0; bus1.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_a = '0; bus3.in_b = '0; bus3.in_sel = '0; bus3.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", 8'(bus1.in_ready), 8'd1);
    check("rst_out_valid", 8'(bus1.out_valid), 8'd0);
    check("rst_out_data", 8'(bus1.out_data), 8'd0);
    check("rst_alu_a", 8'(bus1.alu_a), 8'd0);
    check("rst_out_zero", 8'(bus1.out_zero), 8'd0);
    check("rst_out_carry", 8'(bus1.out_carry), 8'd0);
    check("rst3_in_ready", 8'(bus3.in_ready), 8'd1);
`ifdef ALU_SEQ_STATS_EN
    check("rst_op_count", bus1.op_count, 8'd0);
`endif
    rst = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_op1(vecs[i], i);
    end
`ifdef ALU_SEQ_STATS_EN
    check("table_op_count", bus1.op_count, 8'd8);
`endif

    // Backpressure: hold out_ready low while a second request waits
    bus1.in_valid = 1'b1; bus1.in_a = 4'b0010; bus1.in_b = 4'b0011; bus1.in_sel = 2'b10;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    bus1.in_a = 4'b1000; bus1.in_b = 4'b0001; bus1.in_sel = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_out_valid", i), 8'(bus1.out_valid), 8'd1);
      check($sformatf("bp%0d_out_data", i), 8'(bus1.out_data), 8'b0101);
      check($sformatf("bp%0d_in_ready", i), 8'(bus1.in_ready), 8'd0);
      check($sformatf("bp%0d_alu_a", i), 8'(bus1.alu_a), 8'b0010);
`ifdef ALU_SEQ_STATS_EN
      check($sformatf("bp%0d_stall", i), 8'(bus1.stall), 8'd1);
`endif
      if (i < 4) @(negedge clk);
    end
    bus1.out_ready = 1'b1;
`ifdef ALU_SEQ_STATS_EN
    #1 check("bp_stall_released", 8'(bus1.stall), 8'd0);
`endif
    @(negedge clk);
    check("bp_xfer_valid", 8'(bus1.out_valid), 8'd0);
    check("bp_xfer_in_ready", 8'(bus1.in_ready), 8'd1);
    check("bp_xfer_alu_a_held", 8'(bus1.alu_a), 8'b0010);
    check("bp_xfer_data_kept", 8'(bus1.out_data), 8'b0101);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check("bp_second_in_ready", 8'(bus1.in_ready), 8'd0);
    check("bp_second_alu_a", 8'(bus1.alu_a), 8'b1000);
    check("bp_second_alu_sel", 8'(bus1.alu_sel), 8'b01);
    @(negedge clk);
    check("bp_second_valid", 8'(bus1.out_valid), 8'd1);
    check("bp_second_data", 8'(bus1.out_data), 8'b1001);
    check("bp_second_carry", 8'(bus1.out_carry), 8'd0);
    @(negedge clk);
    check("bp_second_done", 8'(bus1.out_valid), 8'd0);
`ifdef ALU_SEQ_STATS_EN
    check("bp_op_count", bus1.op_count, 8'd10);
    // Saturation: 250 more transfers would reach 260 without the clamp
    bus1.in_valid = 1'b1;
    bus1.out_ready = 1'b1;
    repeat (750) @(negedge clk);
    bus1.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_op_count", bus1.op_count, 8'd255);
`endif

    // Latency with SETTLE_CYCLES=3: valid visible after edge k+3
    bus3.in_valid = 1'b1; bus3.in_a = 4'b0110; bus3.in_b = 4'b0011; bus3.in_sel = 2'b11;
    bus3.out_ready = 1'b1;
    @(negedge clk);
    bus3.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lat3_wait%0d", i), 8'(bus3.out_valid), 8'd0);
      @(negedge clk);
    end
    check("lat3_valid", 8'(bus3.out_valid), 8'd1);
    check("lat3_data", 8'(bus3.out_data), 8'b0011);
    check("lat3_carry", 8'(bus3.out_carry), 8'd0);
    @(negedge clk);
    check("lat3_done", 8'(bus3.out_valid), 8'd0);

    // Reset one cycle after accept discards the operation
    bus3.in_valid = 1'b1; bus3.in_a = 4'b1111; bus3.in_b = 4'b1111; bus3.in_sel = 2'b10;
    @(negedge clk);
    bus3.in_valid = 1'b0;
    check("mid_in_settle", 8'(bus3.in_ready), 8'd0);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    check("mid_rst_in_ready", 8'(bus3.in_ready), 8'd1);
    check("mid_rst_out_valid", 8'(bus3.out_valid), 8'd0);
    check("mid_rst_alu_a", 8'(bus3.alu_a), 8'd0);
    check("mid_rst_alu_b", 8'(bus3.alu_b), 8'd0);
    check("mid_rst_alu_sel", 8'(bus3.alu_sel), 8'd0);
    check("mid_rst_out_data", 8'(bus3.out_data), 8'd0);
    check("mid_rst_out_zero", 8'(bus3.out_zero), 8'd0);
    check("mid_rst_out_carry", 8'(bus3.out_carry), 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mid_no_valid%0d", i), 8'(bus3.out_valid), 8'd0);
`ifdef ALU_SEQ_STATS_EN
      check($sformatf("mid_op_count%0d", i), bus3.op_count, 8'd0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream/downstream wrapper for the 4-bit combinational ALU units (AND, OR, ADD, SUB).
- Upstream side: accepts one operation (operands plus select) per valid/ready handshake and holds `alu_a`, `alu_b` and `alu_sel` stable for the external ALU datapath.
- It waits a programmable settle time, then registers the ALU result and flags.
- Downstream side: presents the captured result with a valid/ready handshake.

Parameters:
- WIDTH, 4: operand and result width in bits.
- SETTLE_CYCLES, 1: cycles the operands are held before the result is captured. Legal range 1..15; 0 is illegal.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: upstream operation valid.
- in_ready, output, 1: block can accept an operation.
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B.
- in_sel, input, 2: operation select. 00 AND, 01 OR, 10 ADD, 11 SUB.
- alu_a, output, WIDTH: registered operand A to the ALU units.
- alu_b, output, WIDTH: registered operand B to the ALU units.
- alu_sel, output, 2: registered select to the ALU result mux.
- alu_res, input, WIDTH: muxed combinational ALU result.
- alu_cout, input, 1: carry out (ADD) or borrow (SUB); don't-care for AND/OR.
- out_valid, output, 1: captured result valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, WIDTH: captured result.
- out_zero, output, 1: high when out_data == 0.
- out_carry, output, 1: captured alu_cout, forced to 0 for AND/OR.

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is synchronous and active-high. Reset has priority over every other action.
- Reset values:
  - in_ready = 1, out_valid = 0.
  - alu_a, alu_b, alu_sel, out_data = 0.
  - out_zero = 0, out_carry = 0.
  - State is IDLE, settle counter = 0.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge k: latch in_a/in_b/in_sel into alu_a/alu_b/alu_sel, load cnt = SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - in_ready = 0; alu_* held constant.
  - If cnt == 0: capture out_data = alu_res, out_zero = (alu_res == 0), out_carry = alu_cout & alu_sel[1], then go to HOLD.
  - Otherwise decrement cnt.
- HOLD:
  - out_valid = 1; out_data and flags stable; alu_* held.
  - On out_valid & out_ready: go to IDLE and clear out_valid.
  - out_data and flags retain their last values after the transfer.
- Latency: with accept at edge k, out_valid is visible after edge k+SETTLE_CYCLES (default: 1 cycle).
- Throughput: at most one operation per SETTLE_CYCLES+2 cycles. No accept in the same cycle as an output transfer; in_ready rises the cycle after the transfer.
- in_valid outside IDLE is ignored; the upstream must hold its request until in_ready.
- out_ready outside HOLD is ignored.
- Arithmetic is performed externally. The block only captures alu_res; the WIDTH-bit result wraps naturally (e.g. 1111 + 0001 gives 0000 with carry 1).
- Reset mid-operation (SETTLE or HOLD): the in-flight operation is discarded, no output transfer occurs, and all outputs return to reset values on the next edge.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- When defined, add output `op_count[7:0]`:
  - Reset to 0.
  - Increments on every out_valid & out_ready transfer.
  - Saturates at 255.
- Add output `stall`: high in any HOLD cycle where out_ready = 0.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
1. Reset then idle: assert rst for 2 cycles -> in_ready = 1, out_valid = 0, out_data = 0000, alu_a = 0000.
2. AND op: in_a = 1101, in_b = 1011, sel = 00, out_ready held 1 -> out_valid 1 cycle after accept, out_data = 1001, out_zero = 0, out_carry = 0.
3. AND zero: in_a = 0100, in_b = 0010, sel = 00 -> out_data = 0000, out_zero = 1.
4. ADD wrap: in_a = 1111, in_b = 0001, sel = 10, ALU model drives 0000/cout 1 -> out_data = 0000, out_zero = 1, out_carry = 1.
5. Backpressure: out_ready = 0 for 5 cycles while new in_valid is asserted -> out_valid and out_data stay stable, in_ready = 0, second op is not accepted until the cycle after the transfer.
6. Reset in SETTLE with SETTLE_CYCLES = 3: assert rst 1 cycle after accept -> no out_valid pulse, all outputs 0; with ALU_SEQ_STATS_EN defined, op_count stays 0.
